// File: rtl/ifu_fetch_buf.sv
// ---------------------------------------------------------------------------
// ifu_fetch_buf
//   Instruction fetch unit with a small instruction FIFO toward the IDU.
//   Owns the fetch PC. Issues one word read at a time to instruction memory.
//   Pushes each returned word, with its PC and a status code, into a
//   DEPTH-entry FIFO. Handles branch/trap redirects by flushing the FIFO and
//   discarding any response that is still in flight. Detects misaligned fetch
//   PCs and tags bus errors.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   redirect_valid/pc load a new fetch PC and flush the FIFO
//   req_valid/ready   memory read request handshake, address on req_addr
//   rsp_valid/data    one response per accepted request; rsp_err = bus error
//   out_valid/ready   FIFO head handshake toward IDU
//   out_inst/pc/err   head entry; err 00 ok, 01 bus error, 10 misaligned
// ---------------------------------------------------------------------------
module ifu_fetch_buf #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h80000000,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [31:0]     rsp_data,
  input  logic            rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [1:0]      out_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_BUS = 2'b01;
  localparam logic [1:0] ERR_MIS = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HALT
  } state_e;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [1:0]      err;
  } entry_t;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic              redir_seen_q, redir_seen_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  entry_t            fifo_mem [DEPTH];
  entry_t            push_entry;
  entry_t            head;
  logic              push;
  logic              pop;
  logic              has_space;

  // -------------------------------------------------------------------------
  // Fetch control: next state, fetch PC and FIFO push request
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_addr_d   = req_addr_q;
    redir_seen_d = redir_seen_q;
    push         = 1'b0;
    push_entry   = '0;
    has_space    = (count_q < DEPTH_C);

    unique case (state_q)
      S_IDLE: begin
        if (!redirect_valid) begin
          if (fetch_pc_q[1:0] != 2'b00) begin
            // Misaligned target: report it through the FIFO once there is
            // room, then stop fetching until the next redirect.
            if (has_space) begin
              push            = 1'b1;
              push_entry.inst = 32'h0;
              push_entry.pc   = fetch_pc_q;
              push_entry.err  = ERR_MIS;
              state_d         = S_HALT;
            end
          end else if (has_space) begin
            // Latch the address so it stays stable even if a redirect
            // rewrites fetch_pc while the request is still pending.
            req_addr_d = fetch_pc_q;
            state_d    = S_REQ;
          end
        end
      end

      S_REQ: begin
        // A request cannot be withdrawn; remember any redirect seen while
        // it is pending so its response is dropped after acceptance.
        if (req_ready) begin
          state_d      = (redir_seen_q || redirect_valid) ? S_DROP : S_WAIT;
          redir_seen_d = 1'b0;
        end else if (redirect_valid) begin
          redir_seen_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          state_d = rsp_valid ? S_IDLE : S_DROP;
        end else if (rsp_valid) begin
          push            = 1'b1;
          push_entry.inst = rsp_data;
          push_entry.pc   = fetch_pc_q;
          push_entry.err  = rsp_err ? ERR_BUS : ERR_OK;
          fetch_pc_d      = fetch_pc_q + XLEN'(4);
          state_d         = rsp_err ? S_HALT : S_IDLE;
        end
      end

      S_DROP: begin
        if (rsp_valid) begin
          state_d = S_IDLE;
        end
      end

      S_HALT: begin
        if (redirect_valid) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO bookkeeping: redirect flush overrides both push and pop
  // -------------------------------------------------------------------------
  always_comb begin
    pop      = out_valid && out_ready && !redirect_valid;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Control state registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      req_addr_q   <= RESET_PC;
      redir_seen_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_addr_q   <= req_addr_d;
      redir_seen_q <= redir_seen_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage (data only, no reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_entry;
    end
  end

  // Outputs are gated by out_valid so an empty FIFO always presents zeros.
  assign head      = fifo_mem[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign out_inst  = out_valid ? head.inst : 32'h0;
  assign out_pc    = out_valid ? head.pc   : '0;
  assign out_err   = out_valid ? head.err  : 2'b00;
  assign req_valid = (state_q == S_REQ);
  assign req_addr  = req_addr_q;

  // Only one request is ever outstanding and it is issued with room
  // reserved, so a push into a full FIFO means the control logic is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !has_space));

endmodule

// File: tb/tb_ifu_fetch_buf.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch_buf
//   Directed bench for ifu_fetch_buf: a per-cycle vector table for the
//   basic fetch stream, then hand-written sequences for backpressure,
//   redirects, bus error, misalignment and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_ifu_fetch_buf;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [1:0]  out_err;

  int n_checks = 0;
  int n_fail   = 0;

  int          rsp_lat  = 1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  err;
  } pop_t;

  logic [31:0] acc_q [$];
  pop_t        pop_q [$];

  typedef struct {
    logic        req_ready;
    logic        out_ready;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_out_valid;
    logic [31:0] exp_out_pc;
    logic [1:0]  exp_out_err;
  } vec_t;

  ifu_fetch_buf #(
    .XLEN    (32),
    .RESET_PC(32'h80000000),
    .DEPTH   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_err       (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'd3 + 32'h0000_0013;
  endfunction

  // Memory responder: one response rsp_lat cycles after each accepted request.
  initial begin
    logic [31:0] a;
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && req_valid && req_ready) begin
        a = req_addr;
        @(posedge clk);
        repeat (rsp_lat - 1) @(posedge clk);
        #1;
        rsp_valid = 1'b1;
        rsp_data  = mem_word(a);
        rsp_err   = (a == err_addr);
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        rsp_data  = 32'h0;
        rsp_err   = 1'b0;
      end
    end
  end

  // Record accepted requests and consumed FIFO entries mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (req_valid && req_ready) acc_q.push_back(req_addr);
      if (out_valid && out_ready && !redirect_valid)
        pop_q.push_back('{pc: out_pc, inst: out_inst, err: out_err});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic chk_pop(input string name, input int idx, input logic [31:0] pc,
                         input logic [31:0] inst, input logic [1:0] err);
    if (idx >= pop_q.size()) begin
      check({name, "_present"}, 64'(pop_q.size()), 64'(idx + 1));
    end else begin
      check({name, "_pc"}, 64'(pop_q[idx].pc), 64'(pc));
      check({name, "_inst"}, 64'(pop_q[idx].inst), 64'(inst));
      check({name, "_err"}, 64'(pop_q[idx].err), 64'(err));
    end
  endtask

  task automatic chk_acc(input string name, input int idx, input logic [31:0] addr);
    if (idx >= acc_q.size()) check({name, "_present"}, 64'(acc_q.size()), 64'(idx + 1));
    else check(name, 64'(acc_q[idx]), 64'(addr));
  endtask

  // Bounded wait for the n-th accepted request; timeout counts as a failure.
  task automatic wait_acc(input string name, input int n, input int budget);
    int i;
    i = 0;
    while (acc_q.size() < n && i < budget) begin
      step();
      i++;
    end
    check({name, "_wait"}, 64'(acc_q.size() >= n), 64'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 64'(req_valid), 64'(0));
    check({tag, "_req_addr"}, 64'(req_addr), 64'h80000000);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_inst"}, 64'(out_inst), 64'(0));
    check({tag, "_out_pc"}, 64'(out_pc), 64'(0));
    check({tag, "_out_err"}, 64'(out_err), 64'(0));
  endtask

  // Drain any in-flight response, hold reset, check reset outputs, and
  // release reset #1 after a rising edge.
  task automatic do_reset(input string tag);
    req_ready      = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    run(8);
    rst = 1'b0;
    run(2);
    chk_reset_outputs(tag);
    acc_q.delete();
    pop_q.delete();
    rsp_lat  = 1;
    err_addr = 32'hFFFF_FFFF;
    rst = 1'b1;
  endtask

  initial begin
    vec_t tbl [9];

    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h80000000, 1'b0, 32'h0,        2'b00};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h80000000, 1'b0, 32'h0,        2'b00};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h80000000, 1'b1, 32'h80000000, 2'b00};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h80000004, 1'b0, 32'h0,        2'b00};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h80000004, 1'b0, 32'h0,        2'b00};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h80000004, 1'b1, 32'h80000004, 2'b00};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h80000008, 1'b0, 32'h0,        2'b00};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 32'h80000008, 1'b0, 32'h0,        2'b00};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 32'h80000008, 1'b1, 32'h80000008, 2'b00};

    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    req_ready      = 1'b0;
    out_ready      = 1'b0;
    rst            = 1'b1;
    #2;
    rst = 1'b0;

    // Basic stream: per-cycle vectors starting at the first edge after reset.
    do_reset("rst1");
    for (int i = 0; i < 9; i++) begin
      req_ready = tbl[i].req_ready;
      out_ready = tbl[i].out_ready;
      step();
      check($sformatf("vec%0d_req_valid", i), 64'(req_valid), 64'(tbl[i].exp_req_valid));
      check($sformatf("vec%0d_req_addr", i), 64'(req_addr), 64'(tbl[i].exp_req_addr));
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].exp_out_valid));
      if (tbl[i].exp_out_valid) begin
        check($sformatf("vec%0d_out_pc", i), 64'(out_pc), 64'(tbl[i].exp_out_pc));
        check($sformatf("vec%0d_out_inst", i), 64'(out_inst), 64'(mem_word(tbl[i].exp_out_pc)));
        check($sformatf("vec%0d_out_err", i), 64'(out_err), 64'(tbl[i].exp_out_err));
      end
    end

    // Backpressure: FIFO fills to 4 entries, fetch stops, then drains.
    do_reset("rst2");
    req_ready = 1'b1;
    run(20);
    check("full_acc_count", 64'(acc_q.size()), 64'(4));
    check("full_req_valid", 64'(req_valid), 64'(0));
    check("full_out_valid", 64'(out_valid), 64'(1));
    check("full_head_pc", 64'(out_pc), 64'h80000000);
    out_ready = 1'b1;
    run(12);
    for (int i = 0; i < 4; i++)
      chk_pop($sformatf("drain%0d", i), i, 32'h80000000 + 32'(4 * i),
              mem_word(32'h80000000 + 32'(4 * i)), 2'b00);
    chk_acc("resume_addr", 4, 32'h80000010);

    // Redirect in WAIT with a late response: response dropped, refetch.
    do_reset("rst3");
    req_ready = 1'b1;
    out_ready = 1'b1;
    rsp_lat   = 3;
    wait_acc("wait_redir", 1, 10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000100;
    step();
    redirect_valid = 1'b0;
    check("wait_redir_flush", 64'(out_valid), 64'(0));
    run(12);
    chk_acc("wait_redir_next", 1, 32'h80000100);
    chk_pop("wait_redir_first", 0, 32'h80000100, mem_word(32'h80000100), 2'b00);

    // Redirect while a request is stalled: address held, response dropped.
    do_reset("rst4");
    req_ready = 1'b1;
    out_ready = 1'b1;
    wait_acc("req_redir", 1, 10);
    req_ready = 1'b0;
    run(2);
    check("stall_req_valid", 64'(req_valid), 64'(1));
    check("stall_req_addr", 64'(req_addr), 64'h80000004);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000200;
    step();
    redirect_valid = 1'b0;
    check("stall_redir_req_valid", 64'(req_valid), 64'(1));
    check("stall_redir_req_addr", 64'(req_addr), 64'h80000004);
    check("stall_redir_out_valid", 64'(out_valid), 64'(0));
    run(2);
    check("stall_hold_addr", 64'(req_addr), 64'h80000004);
    req_ready = 1'b1;
    run(12);
    chk_acc("stall_acc1", 1, 32'h80000004);
    chk_acc("stall_acc2", 2, 32'h80000200);
    chk_pop("stall_pop0", 0, 32'h80000000, mem_word(32'h80000000), 2'b00);
    chk_pop("stall_pop1", 1, 32'h80000200, mem_word(32'h80000200), 2'b00);

    // Bus error on 0x8000000C: tagged entry, fetch halts until redirect.
    do_reset("rst5");
    err_addr  = 32'h8000000C;
    req_ready = 1'b1;
    out_ready = 1'b1;
    run(20);
    check("berr_acc_count", 64'(acc_q.size()), 64'(4));
    check("berr_req_valid", 64'(req_valid), 64'(0));
    chk_pop("berr_ok", 0, 32'h80000000, mem_word(32'h80000000), 2'b00);
    chk_pop("berr_entry", 3, 32'h8000000C, mem_word(32'h8000000C), 2'b01);
    err_addr       = 32'hFFFF_FFFF;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000000;
    step();
    redirect_valid = 1'b0;
    run(8);
    chk_acc("berr_resume", 4, 32'h80000000);

    // Misaligned redirect target, then asynchronous reset during WAIT.
    do_reset("rst6");
    req_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000102;
    step();
    redirect_valid = 1'b0;
    step();
    check("mis_out_valid", 64'(out_valid), 64'(1));
    check("mis_out_pc", 64'(out_pc), 64'h80000102);
    check("mis_out_inst", 64'(out_inst), 64'(0));
    check("mis_out_err", 64'(out_err), 64'(2));
    check("mis_req_valid", 64'(req_valid), 64'(0));
    run(5);
    check("mis_halt_req_valid", 64'(req_valid), 64'(0));
    check("mis_halt_acc", 64'(acc_q.size()), 64'(0));
    check("mis_halt_out_valid", 64'(out_valid), 64'(1));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000040;
    step();
    redirect_valid = 1'b0;
    wait_acc("arst", 2, 12);
    check("arst_pre_out_valid", 64'(out_valid), 64'(1));
    check("arst_pre_req_addr", 64'(req_addr), 64'h80000044);
    rst = 1'b0;
    #1;
    chk_reset_outputs("arst");
    run(2);
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
